// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned NREGS_DEF = 8;
   localparam int unsigned IDX_W_DEF = $clog2(NREGS_DEF);

   typedef logic [IDX_W_DEF-1:0] rf_idx_t;
   typedef logic [WIDTH_DEF-1:0] rf_word_t;

endpackage

// File: rtl/regfile_sb_entry.sv
// One register-file entry: data word plus scoreboard busy flag.
module rf_entry #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic             set_busy,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             busy
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q    <= '0;
         busy <= 1'b0;
      end else begin
         if (we) q <= d;
         // A newer producer issued on the same edge keeps the entry busy.
         if (set_busy)
            busy <= 1'b1;
         else if (we)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with per-entry busy bits and optional
// write-to-read bypass.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int unsigned WIDTH    = WIDTH_DEF,
   parameter  int unsigned NREGS    = NREGS_DEF,
   parameter  bit          BYPASS   = 1'b1,
   parameter  bit          ZERO_REG = 1'b0,
   localparam int unsigned IDX_W    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [IDX_W-1:0] dest,
   input  logic [WIDTH-1:0] in,
   input  logic [IDX_W-1:0] src_a,
   input  logic [IDX_W-1:0] src_b,
   output logic [WIDTH-1:0] reg_a,
   output logic [WIDTH-1:0] reg_b,
   input  logic             mark,
   input  logic [IDX_W-1:0] mark_dest,
   output logic             busy_a,
   output logic             busy_b,
   output logic             busy_any
);

   logic [WIDTH-1:0] q [NREGS];
   logic [NREGS-1:0] busy;

   for (genvar i = 0; i < NREGS; i++) begin : g_ent
      localparam bit HARD0 = ZERO_REG && (i == 0);
      logic we;
      logic sb;

      assign we = load && (dest == IDX_W'(i)) && !HARD0;
      assign sb = mark && (mark_dest == IDX_W'(i)) && !HARD0;

      rf_entry #(
         .WIDTH (WIDTH)
      ) u_entry (
         .clk      (clk),
         .reset    (reset),
         .we       (we),
         .set_busy (sb),
         .d        (in),
         .q        (q[i]),
         .busy     (busy[i])
      );
   end

   // Zero-register and reset overrides are applied last so they also mask
   // the bypass path.
   always_comb begin
      reg_a  = q[src_a];
      busy_a = busy[src_a];
      if (BYPASS && load && (dest == src_a)) begin
         reg_a  = in;
         busy_a = 1'b0;
      end
      if (reset || (ZERO_REG && (src_a == '0))) begin
         reg_a  = '0;
         busy_a = 1'b0;
      end

      reg_b  = q[src_b];
      busy_b = busy[src_b];
      if (BYPASS && load && (dest == src_b)) begin
         reg_b  = in;
         busy_b = 1'b0;
      end
      if (reset || (ZERO_REG && (src_b == '0))) begin
         reg_b  = '0;
         busy_b = 1'b0;
      end
   end

   assign busy_any = |busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: three configurations share one stimulus stream.
module tb_regfile_sb;
   import regfile_pkg::*;

   logic     clk = 1'b0;
   logic     reset;
   logic     load;
   rf_idx_t  dest;
   rf_word_t din;
   rf_idx_t  src_a;
   rf_idx_t  src_b;
   logic     mark;
   rf_idx_t  mark_dest;

   // index 0: bypass, 1: no bypass, 2: bypass + zero register
   logic [2:0][15:0] ra_o;
   logic [2:0][15:0] rb_o;
   logic [2:0]       ba_o;
   logic [2:0]       bb_o;
   logic [2:0]       bany_o;

   always #5 clk = ~clk;

   regfile_sb #(.WIDTH(16), .NREGS(8), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_byp (
      .clk(clk), .reset(reset), .load(load), .dest(dest), .in(din),
      .src_a(src_a), .src_b(src_b), .reg_a(ra_o[0]), .reg_b(rb_o[0]),
      .mark(mark), .mark_dest(mark_dest), .busy_a(ba_o[0]), .busy_b(bb_o[0]),
      .busy_any(bany_o[0]));

   regfile_sb #(.WIDTH(16), .NREGS(8), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_nobyp (
      .clk(clk), .reset(reset), .load(load), .dest(dest), .in(din),
      .src_a(src_a), .src_b(src_b), .reg_a(ra_o[1]), .reg_b(rb_o[1]),
      .mark(mark), .mark_dest(mark_dest), .busy_a(ba_o[1]), .busy_b(bb_o[1]),
      .busy_any(bany_o[1]));

   regfile_sb #(.WIDTH(16), .NREGS(8), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_zero (
      .clk(clk), .reset(reset), .load(load), .dest(dest), .in(din),
      .src_a(src_a), .src_b(src_b), .reg_a(ra_o[2]), .reg_b(rb_o[2]),
      .mark(mark), .mark_dest(mark_dest), .busy_a(ba_o[2]), .busy_b(bb_o[2]),
      .busy_any(bany_o[2]));

   typedef struct {
      int          dut;
      string       name;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        ba;
      logic        bb;
      logic        bany;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   // reference state for the randomised phase
   logic [15:0] m_mem  [3][8];
   logic        m_busy [3][8];

   task automatic push(input int d, input string nm, input logic [15:0] ra,
                       input logic [15:0] rb, input logic ba, input logic bb,
                       input logic bany);
      exp_t e;
      e.dut = d; e.name = nm; e.ra = ra; e.rb = rb; e.ba = ba; e.bb = bb; e.bany = bany;
      sbq.push_back(e);
   endtask

   task automatic cmp(input string nm, input int d, input string fld,
                      input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d %s: got %h expected %h", nm, d, fld, act, exp);
      end
   endtask

   // monitor: outputs are stable at the falling edge
   always @(negedge clk) begin
      while (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         cmp(e.name, e.dut, "reg_a",    ra_o[e.dut],           e.ra);
         cmp(e.name, e.dut, "reg_b",    rb_o[e.dut],           e.rb);
         cmp(e.name, e.dut, "busy_a",   16'(ba_o[e.dut]),      16'(e.ba));
         cmp(e.name, e.dut, "busy_b",   16'(bb_o[e.dut]),      16'(e.bb));
         cmp(e.name, e.dut, "busy_any", 16'(bany_o[e.dut]),    16'(e.bany));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_read(input int d, input rf_idx_t src,
                             output logic [15:0] data, output logic b);
      bit byp = (d != 1);
      bit zr  = (d == 2);
      if (reset || (zr && src == 0)) begin
         data = 16'h0; b = 1'b0;
      end else if (byp && load && dest == src) begin
         data = din; b = 1'b0;
      end else begin
         data = m_mem[d][src]; b = m_busy[d][src];
      end
   endtask

   task automatic model_push(input string nm);
      logic [15:0] ra, rb;
      logic        ba, bb, bany;
      for (int d = 0; d < 3; d++) begin
         model_read(d, src_a, ra, ba);
         model_read(d, src_b, rb, bb);
         bany = 1'b0;
         for (int k = 0; k < 8; k++) bany |= m_busy[d][k];
         push(d, nm, ra, rb, ba, bb, bany);
      end
   endtask

   task automatic model_clock();
      for (int d = 0; d < 3; d++) begin
         bit zr = (d == 2);
         if (reset) begin
            for (int k = 0; k < 8; k++) begin
               m_mem[d][k] = 16'h0; m_busy[d][k] = 1'b0;
            end
         end else begin
            if (load && !(zr && dest == 0)) begin
               m_mem[d][dest] = din; m_busy[d][dest] = 1'b0;
            end
            if (mark && !(zr && mark_dest == 0)) m_busy[d][mark_dest] = 1'b1;
         end
      end
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; dest = '0; din = '0;
      src_a = '0; src_b = '0; mark = 1'b0; mark_dest = '0;
      for (int d = 0; d < 3; d++) push(d, "reset_hold", 16'h0, 16'h0, 0, 0, 0);
      step();
      step();
      reset = 1'b0;

      // all entries read zero after reset
      for (int i = 0; i < 8; i++) begin
         step();
         src_a = rf_idx_t'(i);
         src_b = rf_idx_t'(7 - i);
         push(0, "reset_read", 16'h0, 16'h0, 0, 0, 0);
      end

      // write with and without bypass
      step();
      load = 1'b1; dest = 3'd5; din = 16'h1234; src_a = 3'd0; src_b = 3'd5;
      push(0, "wr_bypass", 16'h0, 16'h1234, 0, 0, 0);
      push(1, "wr_nobypass", 16'h0, 16'h0, 0, 0, 0);
      step();
      load = 1'b0; src_a = 3'd5;
      push(0, "wr_latency", 16'h1234, 16'h1234, 0, 0, 0);
      push(1, "wr_latency", 16'h1234, 16'h1234, 0, 0, 0);

      // mark then clear by writeback
      step();
      mark = 1'b1; mark_dest = 3'd2; src_a = 3'd2; src_b = 3'd2;
      push(0, "mark_same_cycle", 16'h0, 16'h0, 0, 0, 0);
      step();
      mark = 1'b0;
      push(0, "mark_busy", 16'h0, 16'h0, 1, 1, 1);
      push(1, "mark_busy", 16'h0, 16'h0, 1, 1, 1);
      step();
      load = 1'b1; dest = 3'd2; din = 16'h00AA;
      push(0, "clear_bypass", 16'h00AA, 16'h00AA, 0, 0, 1);
      push(1, "clear_nobypass", 16'h0, 16'h0, 1, 1, 1);
      step();
      load = 1'b0;
      push(0, "clear_after", 16'h00AA, 16'h00AA, 0, 0, 0);
      push(1, "clear_after", 16'h00AA, 16'h00AA, 0, 0, 0);

      // load and mark on the same index: mark wins
      step();
      load = 1'b1; dest = 3'd4; din = 16'h5555; mark = 1'b1; mark_dest = 3'd4;
      src_a = 3'd4; src_b = 3'd4;
      push(0, "ldmark_bypass", 16'h5555, 16'h5555, 0, 0, 0);
      step();
      load = 1'b0; mark = 1'b0;
      push(0, "ldmark_after", 16'h5555, 16'h5555, 1, 1, 1);
      push(1, "ldmark_after", 16'h5555, 16'h5555, 1, 1, 1);
      step();
      load = 1'b1;
      step();
      load = 1'b0;

      // zero register ignores writes and marks
      step();
      load = 1'b1; dest = 3'd0; din = 16'hFFFF; mark = 1'b1; mark_dest = 3'd0;
      src_a = 3'd0; src_b = 3'd5;
      push(2, "zero_wr_cycle", 16'h0, 16'h1234, 0, 0, 0);
      push(0, "r0_wr_cycle", 16'hFFFF, 16'h1234, 0, 0, 0);
      step();
      load = 1'b0; mark = 1'b0;
      push(2, "zero_after", 16'h0, 16'h1234, 0, 0, 0);
      push(0, "r0_after", 16'hFFFF, 16'h1234, 1, 0, 1);

      // asynchronous reset mid-cycle; load/mark ignored while held
      step();
      load = 1'b1; dest = 3'd3; din = 16'hBEEF; src_a = 3'd3; src_b = 3'd0;
      step();
      load = 1'b0;
      push(0, "beef_stored", 16'hBEEF, 16'hFFFF, 0, 1, 1);
      step();
      #1;
      reset = 1'b1; load = 1'b1; din = 16'h1111; mark = 1'b1; mark_dest = 3'd3;
      for (int d = 0; d < 3; d++) push(d, "async_reset", 16'h0, 16'h0, 0, 0, 0);
      step();
      for (int d = 0; d < 3; d++) push(d, "reset_held", 16'h0, 16'h0, 0, 0, 0);
      step();
      reset = 1'b0; load = 1'b0; mark = 1'b0;
      push(0, "post_reset", 16'h0, 16'h0, 0, 0, 0);
      push(2, "post_reset", 16'h0, 16'h0, 0, 0, 0);
      step();

      // randomised traffic against the reference model
      for (int d = 0; d < 3; d++)
         for (int k = 0; k < 8; k++) begin
            m_mem[d][k] = 16'h0; m_busy[d][k] = 1'b0;
         end
      for (int n = 0; n < 2000; n++) begin
         load      = 1'($urandom_range(0, 1));
         mark      = ($urandom_range(0, 3) == 0);
         din       = 16'($urandom);
         dest      = rf_idx_t'($urandom_range(0, 7));
         mark_dest = rf_idx_t'($urandom_range(0, 7));
         src_a     = rf_idx_t'($urandom_range(0, 7));
         src_b     = rf_idx_t'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            src_a = dest; src_b = dest; mark_dest = dest;
         end
         model_push("random");
         @(posedge clk);
         model_clock();
         #1;
      end
      load = 1'b0; mark = 1'b0;

      @(negedge clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-entry register file that succeeds the single load-enabled register for the pipelined datapath.
- Provides two combinational read ports and one write port, with an optional write-to-read bypass.
- Each entry carries a busy (scoreboard) bit so the decode stage can detect RAW hazards on in-flight destinations.
- Sits between decode (read/mark) and writeback (write/clear).

Parameters:
- WIDTH, 16, data bits per entry
- NREGS, 8, number of entries; power of two, at least 2
- IDX_W, $clog2(NREGS), index width; derived, never overridden
- BYPASS, 1, 1 = same-cycle write data and clear forwarded to read ports
- ZERO_REG, 0, 1 = entry 0 reads 0, ignores writes, never busy

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all entries and busy bits
- load  in  1  write enable (writeback)
- dest  in  IDX_W  write index
- in  in  WIDTH  write data
- src_a  in  IDX_W  read index A
- src_b  in  IDX_W  read index B
- reg_a  out  WIDTH  read data A
- reg_b  out  WIDTH  read data B
- mark  in  1  set busy on mark_dest (decode issues a producer)
- mark_dest  in  IDX_W  index to mark busy
- busy_a  out  1  scoreboard state of src_a
- busy_b  out  1  scoreboard state of src_b
- busy_any  out  1  OR of all busy bits (drain/flush check)

Behaviour:
- Reset (asynchronous, active-high):
  - All entries go to 0 and all busy bits to 0 immediately, without waiting for a clock edge.
  - While reset is high, reg_a, reg_b, busy_a, busy_b and busy_any are all 0.
  - load and mark are ignored while reset is high.
- Write:
  - On posedge clk with load=1, entry[dest] <= in and busy[dest] <= 0.
  - Write latency is 1 cycle: the stored value is readable from the cycle after the edge.
- Mark: on posedge clk with mark=1, busy[mark_dest] <= 1.
- Simultaneous load and mark to the same index: mark wins. Data is written and the busy bit ends at 1, because a newer producer has issued.
- Reads are combinational from the current state:
  - reg_x = entry[src_x] and busy_x = busy[src_x].
  - If BYPASS=1 and load=1 and dest==src_x: reg_x = in and busy_x = 0, in the same cycle, independent of mark.
  - If BYPASS=0: no forwarding; the old data and old busy value are seen until the edge.
- Both read ports may address the same index; they behave identically.
- ZERO_REG=1:
  - Writes to index 0 are dropped and marks to index 0 are dropped.
  - reg_x = 0 and busy_x = 0 when src_x = 0, including the bypass path.
- busy_any is registered state only (OR of busy bits); it is not affected by the bypass.
- Reset asserted mid-operation discards any in-progress write or mark on that edge; state is 0 after release.
- Index width equals log2(NREGS), so out-of-range indices cannot occur.

Decomposition:
- Package regfile_pkg holds:
  - the default WIDTH/NREGS constants
  - typedef rf_idx_t (logic [IDX_W-1:0])
  - typedef rf_word_t (logic [WIDTH-1:0])
- One natural sub-module, rf_entry:
  - holds the data plus busy flop with async reset
  - inputs: we, set_busy, d
  - outputs: q, busy
  - implements the mark-over-clear priority locally
- Top level generates NREGS rf_entry instances and adds the read mux plus bypass logic.

Test Plan (WIDTH=16, NREGS=8 unless stated):
- Reset then read all indices -> every reg_x = 0x0000 and busy_x = 0. Assert reset asynchronously mid-cycle after writing 0xBEEF to R3 -> reg_a reads 0x0000 (src_a=3) before the next edge.
- load=1, dest=5, in=0x1234 for one cycle, then src_a=5 -> reg_a = 0x1234 the following cycle. BYPASS=1 with src_b=5 during the write cycle -> reg_b = 0x1234 in that same cycle. BYPASS=0 -> reg_b shows the prior value.
- mark=1, mark_dest=2 -> next cycle busy_a = 1 (src_a=2) and busy_any = 1. Then load dest=2, in=0x00AA -> busy_a = 0 in the write cycle under bypass and after the edge; busy_any = 0.
- Same-edge load dest=4, in=0x5555 and mark mark_dest=4 -> entry 4 = 0x5555 and busy[4] = 1 afterwards.
- ZERO_REG=1: load dest=0, in=0xFFFF, plus mark on 0 -> reg_a = 0x0000 (src_a=0), busy_a = 0, busy_any unchanged.
- Random write/mark/read sequence of 2000 cycles against a reference model, covering all dest==src_a==src_b collisions -> no mismatches.
